// File: rtl/mock_bus_pkg.sv
// Shared types and I/O register map for the mock_bus responder and its timer.
package mock_bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] REG_RELOAD_LO = 2'd0;
  localparam logic [1:0] REG_RELOAD_HI = 2'd1;
  localparam logic [1:0] REG_CTRL      = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_FLAG_BIT   = 0;

endpackage

// File: rtl/mock_timer.sv
// Periodic interrupt timer behind the 4-byte I/O window: reload, down-counter,
// control and a sticky flag driving the registered active-low IRQ.
module mock_timer
  import mock_bus_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       wr_en_i,
  input  logic [1:0] offset_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  output logic       irq_n_o
);

  logic [15:0] reload_q;
  logic [15:0] count_q;
  logic        enable_q;
  logic        irq_en_q;
  logic        flag_q;
  logic        irq_n_q;
  logic        expire;

  assign expire  = enable_q && (count_q == 16'd0);
  assign irq_n_o = irq_n_q;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      reload_q <= 16'd0;
      count_q  <= 16'd0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      flag_q   <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      irq_n_q <= !(flag_q && irq_en_q);
      if (enable_q) begin
        count_q <= expire ? reload_q : count_q - 16'd1;
      end
      if (wr_en_i) begin
        case (offset_i)
          REG_RELOAD_LO: reload_q[7:0] <= wr_data_i;
          REG_RELOAD_HI: begin
            reload_q[15:8] <= wr_data_i;
            count_q        <= {wr_data_i, reload_q[7:0]};
          end
          REG_CTRL: begin
            enable_q <= wr_data_i[CTRL_EN_BIT];
            irq_en_q <= wr_data_i[CTRL_IRQ_EN_BIT];
          end
          default: if (wr_data_i[STAT_FLAG_BIT]) flag_q <= 1'b0;
        endcase
      end
      // Placed after the W1C so a same-cycle expiry keeps the flag set.
      if (expire) flag_q <= 1'b1;
    end
  end

  always_comb begin
    rd_data_o = 8'd0;
    case (offset_i)
      REG_RELOAD_LO: rd_data_o = reload_q[7:0];
      REG_RELOAD_HI: rd_data_o = reload_q[15:8];
      REG_CTRL: begin
        rd_data_o[CTRL_EN_BIT]     = enable_q;
        rd_data_o[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      default: rd_data_o[STAT_FLAG_BIT] = flag_q;
    endcase
  end

endmodule

// File: rtl/mock_bus.sv
// CPU-side bus responder: address decode, I/O wait-state FSM, behavioural RAM
// with a testbench load port, and the registered read mux.
module mock_bus
  import mock_bus_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE  = 16'hE800,
  parameter int                  IO_WAIT    = 0
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  input  logic                  cpu_we_n_i,
  output logic                  cpu_ready_o,
  output logic                  irq_n_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i
);

  localparam bit         HAS_WAIT  = (IO_WAIT != 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(IO_WAIT - 1) : 4'd0;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   mem [0:(1<<ADDR_WIDTH)-1];
  logic                    io_hit;
  logic                    access_done;
  logic [7:0]              timer_rd;

  assign io_hit      = (cpu_addr_i[ADDR_WIDTH-1:2] == IO_BASE[ADDR_WIDTH-1:2]);
  assign access_done = cpu_ready_o && reset_n_i;
  assign cpu_data_o  = data_q;

  always_comb begin
    cpu_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: cpu_ready_o = !(io_hit && HAS_WAIT);
      ST_WAIT: cpu_ready_o = (cnt_q == 4'd0);
      default: cpu_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io_hit && HAS_WAIT) begin
            state_q <= ST_WAIT;
            cnt_q   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Load port is ungated and written last so it wins a same-address collision.
  always_ff @(posedge clock_i) begin
    if (access_done && !cpu_we_n_i && !io_hit) mem[cpu_addr_i] <= cpu_data_i;
    if (load_we_i) mem[load_addr_i] <= load_data_i;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
    end else if (access_done && cpu_we_n_i) begin
      data_q <= io_hit ? DATA_WIDTH'(timer_rd) : mem[cpu_addr_i];
    end
  end

  mock_timer u_timer (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .wr_en_i   (access_done && !cpu_we_n_i && io_hit),
    .offset_i  (cpu_addr_i[1:0]),
    .wr_data_i (cpu_data_i[7:0]),
    .rd_data_o (timer_rd),
    .irq_n_o   (irq_n_o)
  );

endmodule

// File: tb/tb_mock_bus.sv
// Scoreboard bench for mock_bus: the driver queues expected read data, a monitor
// compares it on the cycle after each completed read.
module tb_mock_bus;

  localparam logic [15:0] IO_A   = 16'hE800;
  localparam logic [15:0] IDLE_A = 16'h0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_we_n;
  logic        cpu_ready;
  logic        irq_n;
  logic        load_we;
  logic [15:0] load_addr;
  logic [7:0]  load_data;

  logic        rd_req  = 1'b0;
  logic        rd_fire = 1'b0;
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mock_bus #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .IO_BASE    (16'hE800),
    .IO_WAIT    (2)
  ) dut (
    .clock_i     (clk),
    .reset_n_i   (reset_n),
    .cpu_addr_i  (cpu_addr),
    .cpu_data_i  (cpu_data_in),
    .cpu_data_o  (cpu_data_out),
    .cpu_we_n_i  (cpu_we_n),
    .cpu_ready_o (cpu_ready),
    .irq_n_o     (irq_n),
    .load_we_i   (load_we),
    .load_addr_i (load_addr),
    .load_data_i (load_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  // Monitor: a read that completed on the last edge presents data now.
  always @(posedge clk) rd_fire <= cpu_ready && cpu_we_n && rd_req && reset_n;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got %0h expected no read", cpu_data_out);
      end else begin
        check("rd_data", {24'd0, cpu_data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    #1;
    while (!cpu_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
    cpu_addr = a;
    cpu_we_n = 1'b1;
    rd_req   = 1'b1;
    exp_q.push_back(exp);
    wait_done();
    rd_req   = 1'b0;
    cpu_addr = IDLE_A;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_we_n    = 1'b0;
    wait_done();
    cpu_we_n    = 1'b1;
    cpu_addr    = IDLE_A;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    cpu_addr    = IDLE_A;
    cpu_data_in = 8'd0;
    cpu_we_n    = 1'b1;
    load_we     = 1'b0;
    load_addr   = 16'd0;
    load_data   = 8'd0;

    // Program preload while the CPU is held in reset.
    @(negedge clk);
    load_we = 1'b1; load_addr = 16'h0000; load_data = 8'hA9;
    @(negedge clk);
    load_we = 1'b0;
    @(negedge clk);
    check("rst_data",  {24'd0, cpu_data_out}, 32'h00);
    check("rst_irq",   {31'd0, irq_n}, 32'd1);
    check("rst_ready", {31'd0, cpu_ready}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, cpu_ready}, 32'd1);

    // RAM: zero-wait read, write/readback, load-port collision.
    cpu_addr = 16'h0000;
    #1 check("ram_ready", {31'd0, cpu_ready}, 32'd1);
    cpu_read(16'h0000, 8'hA9);
    cpu_write(16'h1234, 8'h55);
    cpu_read(16'h1234, 8'h55);
    load_we = 1'b1; load_addr = 16'h1234; load_data = 8'hAA;
    cpu_write(16'h1234, 8'h66);
    load_we = 1'b0;
    cpu_read(16'h1234, 8'hAA);

    // I/O read with two wait states.
    cpu_addr = IO_A + 16'd3;
    cpu_we_n = 1'b1;
    rd_req   = 1'b1;
    exp_q.push_back(8'h00);
    #1 check("io_rdy0", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk);
    #1 check("io_rdy1", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk);
    #1 check("io_rdy2", {31'd0, cpu_ready}, 32'd1);
    @(negedge clk);
    rd_req   = 1'b0;
    cpu_addr = IDLE_A;

    // Timer: reload 3, enable with IRQ; IRQ low five cycles after the control write.
    cpu_write(IO_A + 16'd0, 8'h03);
    cpu_write(IO_A + 16'd1, 8'h00);
    cpu_read(IO_A + 16'd0, 8'h03);
    cpu_write(IO_A + 16'd2, 8'h03);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("irq_k%0d", k), {31'd0, irq_n}, (k < 5) ? 32'd1 : 32'd0);
    end

    // Freeze the counter, then clear the flag with W1C.
    cpu_write(IO_A + 16'd2, 8'h02);
    cpu_read(IO_A + 16'd2, 8'h02);
    cpu_read(IO_A + 16'd3, 8'h01);
    cpu_write(IO_A + 16'd3, 8'h01);
    check("w1c_irq_hold", {31'd0, irq_n}, 32'd0);
    @(negedge clk);
    check("w1c_irq_high", {31'd0, irq_n}, 32'd1);
    cpu_read(IO_A + 16'd3, 8'h00);

    // Re-enable with counter 3: W1C commits on the expiry edge, set must win.
    cpu_write(IO_A + 16'd2, 8'h03);
    @(negedge clk);
    cpu_write(IO_A + 16'd3, 8'h01);
    check("sw_irq_pre", {31'd0, irq_n}, 32'd1);
    @(negedge clk);
    check("sw_irq_low", {31'd0, irq_n}, 32'd0);
    cpu_read(IO_A + 16'd3, 8'h01);

    // Reset during a pending I/O write to control.
    cpu_addr    = IO_A + 16'd2;
    cpu_data_in = 8'h01;
    cpu_we_n    = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rstw_irq",  {31'd0, irq_n}, 32'd1);
    check("rstw_data", {24'd0, cpu_data_out}, 32'h00);
    cpu_addr = IDLE_A;
    cpu_we_n = 1'b1;
    #1 check("rstw_idle", {31'd0, cpu_ready}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    cpu_read(IO_A + 16'd2, 8'h00);
    cpu_read(IO_A + 16'd0, 8'h00);
    cpu_read(16'h0000, 8'hA9);

    @(negedge clk);
    @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
